// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI slave, the RX frame buffer and the TX feeder.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } spi_state_e;

  // Slave pipeline latency: one load cycle plus the unload register.
  localparam int unsigned SPI_LAT_DEFAULT = 2;

  // Width of an occupancy count for a power-of-2 FIFO of the given depth.
  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo_if.sv
// spi_rx_fifo_if: read-side bus of the SPI RX frame buffer.
// master = local logic draining the FIFO, slave = the frame buffer.
interface spi_rx_fifo_if
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) ();

  logic                         rd_en;
  logic [DATA_W-1:0]            rd_data;
  logic                         rd_valid;
  logic                         full;
  logic [level_w(DEPTH)-1:0]    level;
  logic                         overflow;
  logic                         frame_err;

  modport master (
    output rd_en,
    input  rd_data, rd_valid, full, level, overflow, frame_err
  );

  modport slave (
    input  rd_en,
    output rd_data, rd_valid, full, level, overflow, frame_err
  );

endinterface

// File: rtl/spi_rx_fifo_mem.sv
// spi_rx_fifo_mem: storage, pointers and occupancy for the SPI RX frame buffer.
// Build option: SPI_RX_FWFT_EN selects first-word fall-through read data;
// otherwise rd_data is registered and loads on an accepted pop.
module spi_rx_fifo_mem
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LW     = level_w(DEPTH)
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic [LW-1:0]     level,
  output logic              drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_valid = !empty;
  assign level    = LW'(wptr - rptr);

  // A pop on the same edge frees a slot, so a write while full is still taken.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign drop   = wr_en && full && !rd_acc;

  // Pointer update; both wrap naturally through the extra MSB.
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge spi_clk) begin
    if (wr_acc) mem[wptr[AW-1:0]] <= wr_data;
  end

`ifdef SPI_RX_FWFT_EN
  assign rd_data = mem[rptr[AW-1:0]];
`else
  // Registered read: load head on an accepted pop, hold otherwise.
  always_ff @(posedge spi_clk) begin
    if (rst)         rd_data <= '0;
    else if (rd_acc) rd_data <= mem[rptr[AW-1:0]];
  end
`endif

endmodule

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: tracks chip-select frames from the SPI slave, captures the
// parallel receive word at frame end, right-justifies it and buffers it.
// Build option: SPI_RX_FWFT_EN (first-word fall-through read data).
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LAT    = SPI_LAT_DEFAULT,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic              spi_clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [CNT_W:0]    size,
  input  logic [DATA_W-1:0] rx_data,
  spi_rx_fifo_if.slave      rd
);

  localparam int unsigned    CW       = $clog2(DATA_W + LAT + 1);
  localparam logic [CNT_W:0] DATA_W_C = (CNT_W+1)'(DATA_W);

  spi_state_e        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [CNT_W:0]    size_q, size_n;
  logic [CNT_W:0]    shamt;
  logic [CW-1:0]     cnt_load;
  logic              size_ok;
  logic              err_set;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              drop;
  logic              overflow;
  logic              frame_err;

  assign size_ok  = (size != '0) && (size <= DATA_W_C);
  assign cnt_load = CW'(size) + CW'(LAT);
  assign shamt    = DATA_W_C - size_q;
  assign wr_data  = rx_data >> shamt;

  // State, frame counter, latched size and sticky flags.
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      size_q    <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      size_q <= size_n;
      if (drop)    overflow  <= 1'b1;
      if (err_set) frame_err <= 1'b1;
    end
  end

  // Frame sequencing; CAPTURE doubles as cycle 0 of a back-to-back frame.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    size_n  = size_q;
    err_set = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      ST_IDLE, ST_CAPTURE: begin
        wr_en = (state == ST_CAPTURE);
        if (!cs) begin
          size_n = size;
          if (size_ok) begin
            cnt_n   = cnt_load;
            state_n = ST_COUNT;
          end else begin
            err_set = 1'b1;
            state_n = ST_DRAIN;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (cs) begin
          err_set = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
          if (cnt <= CW'(2)) state_n = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (cs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  spi_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd.rd_en),
    .rd_data  (rd.rd_data),
    .rd_valid (rd.rd_valid),
    .full     (rd.full),
    .level    (rd.level),
    .drop     (drop)
  );

  assign rd.overflow  = overflow;
  assign rd.frame_err = frame_err;

endmodule
